// File: rtl/fwft_stream_pkg.sv
// ---------------------------------------------------------------------------
// fwft_stream_pkg
// Shared constants and helpers for the FWFT-FIFO to valid/ready stream bridge.
//   BEAT_CNT_W : width of the beat-within-packet index
//   PKT_CNT_W  : width of the completed-packet counter
//   SKID_DEPTH : number of entries in the output buffer
//   OCC_W      : width needed to hold an occupancy of 0..SKID_DEPTH
// ---------------------------------------------------------------------------
package fwft_stream_pkg;

    localparam int BEAT_CNT_W = 16;
    localparam int PKT_CNT_W  = 16;
    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = 2;

    // Operation applied to the buffer on a clock edge. The encoding is
    // {push, pop}, so the two request bits can be cast straight into it.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } skid_op_e;

    // Advance a beat index, wrapping to zero after the last beat of a packet.
    function automatic logic [BEAT_CNT_W-1:0] next_beat(
        input logic [BEAT_CNT_W-1:0] beat,
        input logic [BEAT_CNT_W-1:0] last_idx
    );
        return (beat == last_idx) ? '0 : beat + BEAT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/stream_skid2.sv
// ---------------------------------------------------------------------------
// stream_skid2
// Two-entry in-order buffer sitting between the FIFO pop side and the stream
// output. Entry 0 is always the oldest word and drives the head output.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_flush      : synchronous discard of all buffered entries
//   i_push       : write i_push_data into the buffer this edge
//   i_push_data  : word being written
//   i_pop        : remove the head entry this edge
//   o_valid      : buffer holds at least one entry
//   o_full       : buffer holds SKID_DEPTH entries
//   o_head       : oldest entry
// The caller must never push when full (unless also popping) and never pop
// when empty; both are checked by assertions in simulation.
// ---------------------------------------------------------------------------
module stream_skid2
    import fwft_stream_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic          o_valid,
    output logic          o_full,
    output logic [DW-1:0] o_head
);

    logic [OCC_W-1:0] r_occ;
    logic [DW-1:0]    r_mem0;
    logic [DW-1:0]    r_mem1;
    skid_op_e         w_op;

    assign w_op = skid_op_e'({i_push, i_pop});

    // Occupancy and storage update. A push lands in the first free slot; a pop
    // shifts entry 1 down into entry 0 so the head is always r_mem0. On a
    // simultaneous push and pop with one entry held, the new word goes straight
    // to the head; with two held, the shift and the refill of entry 1 happen
    // together. Flush only clears the occupancy, the stale words are harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ  <= '0;
            r_mem0 <= '0;
            r_mem1 <= '0;
        end else if (i_flush) begin
            r_occ <= '0;
        end else begin
            case (w_op)
                OP_PUSH: begin
                    if (r_occ == '0) begin
                        r_mem0 <= i_push_data;
                    end else begin
                        r_mem1 <= i_push_data;
                    end
                    r_occ <= r_occ + OCC_W'(1);
                end
                OP_POP: begin
                    r_mem0 <= r_mem1;
                    r_occ  <= r_occ - OCC_W'(1);
                end
                OP_BOTH: begin
                    if (r_occ == OCC_W'(1)) begin
                        r_mem0 <= i_push_data;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_valid = (r_occ != '0);
    assign o_full  = (r_occ == OCC_W'(SKID_DEPTH));
    assign o_head  = r_mem0;

    // Occupancy must stay within 0..SKID_DEPTH and the caller must respect
    // the empty/full flags.
    a_occ_bound: assert property (@(posedge clk) disable iff (rst)
        r_occ <= OCC_W'(SKID_DEPTH));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        (i_pop && !i_flush) |-> (r_occ != '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (i_push && !i_pop && !i_flush) |-> (r_occ != OCC_W'(SKID_DEPTH)));

endmodule

// File: rtl/fwft_stream_bridge.sv
// ---------------------------------------------------------------------------
// fwft_stream_bridge
// Drains a first-word-fall-through FIFO read port into a valid/ready stream,
// marking packet boundaries with m_last and counting completed packets.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   fifo_empty    : FIFO empty flag; fifo_rd_data is valid when low
//   fifo_rd_data  : FIFO head word
//   fifo_rd_en    : pop the FIFO head at the next rising edge
//   flush         : drop buffered beats and restart the packet beat index
//   m_valid/m_ready/m_data/m_last : output stream
//   pkt_count     : number of packets completed, wrapping at 16 bits
// Parameters:
//   DATA_WIDTH_BYTES : data width in bytes (DW = 8 * DATA_WIDTH_BYTES)
//   PKT_BEATS        : beats per packet, 1..65535
// ---------------------------------------------------------------------------
module fwft_stream_bridge
    import fwft_stream_pkg::*;
#(
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int PKT_BEATS        = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fifo_empty,
    input  logic [8*DATA_WIDTH_BYTES-1:0] fifo_rd_data,
    output logic                          fifo_rd_en,
    input  logic                          flush,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [8*DATA_WIDTH_BYTES-1:0] m_data,
    output logic                          m_last,
    output logic [PKT_CNT_W-1:0]          pkt_count
);

    localparam int DW = 8 * DATA_WIDTH_BYTES;
    localparam logic [BEAT_CNT_W-1:0] LAST_IDX = BEAT_CNT_W'(PKT_BEATS - 1);

    logic                  w_full;
    logic                  w_valid;
    logic [DW-1:0]         w_head;
    logic                  w_xfer;
    logic [BEAT_CNT_W-1:0] r_beat;
    logic [PKT_CNT_W-1:0]  r_pkt_count;

    // The pop decision looks only at the registered full flag, never at
    // m_ready, so the FIFO read enable has no combinational path from the
    // downstream ready. The 2-deep buffer absorbs the resulting one-cycle
    // lag and still sustains one beat per cycle.
    assign fifo_rd_en = !fifo_empty && !w_full && !flush && !rst;

    // A flush in the same cycle as a handshake wins: the beat is dropped and
    // neither the beat index nor the packet counter sees it.
    assign w_xfer = w_valid && m_ready && !flush;

    stream_skid2 #(
        .DW (DW)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (flush),
        .i_push      (fifo_rd_en),
        .i_push_data (fifo_rd_data),
        .i_pop       (w_xfer),
        .o_valid     (w_valid),
        .o_full      (w_full),
        .o_head      (w_head)
    );

    // Beat index within the current packet and the completed-packet counter.
    // Both move only on a real handshake; flush restarts the packet but keeps
    // the history of completed packets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat      <= '0;
            r_pkt_count <= '0;
        end else if (flush) begin
            r_beat <= '0;
        end else if (w_xfer) begin
            r_beat <= next_beat(r_beat, LAST_IDX);
            if (r_beat == LAST_IDX) begin
                r_pkt_count <= r_pkt_count + PKT_CNT_W'(1);
            end
        end
    end

    assign m_valid   = w_valid;
    assign m_data    = w_head;
    assign m_last    = w_valid && (r_beat == LAST_IDX);
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_fwft_stream_bridge.sv
// ---------------------------------------------------------------------------
// tb_fwft_stream_bridge
// Directed bench for fwft_stream_bridge with 32-bit data and 4-beat packets:
// a per-cycle vector table for the basic handshakes, then hand-written
// sequences for streaming, backpressure, flush, reset and a randomized drain.
// ---------------------------------------------------------------------------
module tb_fwft_stream_bridge;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [15:0]   pkt_count;

    int checks = 0;
    int passes = 0;

    logic [DW-1:0] srcQ[$];
    logic [DW-1:0] outData[$];
    bit            outLast[$];
    int            outCycle[$];
    int            cycleNo = 0;
    int            popCount = 0;
    logic          lastRdEn;

    typedef struct {
        logic          empty;
        logic [DW-1:0] rdData;
        logic          ready;
        logic          flushIn;
        logic          expRdEn;
        logic          expValid;
        logic          checkData;
        logic [DW-1:0] expData;
        logic          expLast;
        logic [15:0]   expPkt;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    fwft_stream_bridge #(
        .DATA_WIDTH_BYTES (4),
        .PKT_BEATS        (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .pkt_count    (pkt_count)
    );

    // Global time limit so a stuck DUT can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic e, input logic [DW-1:0] d, input logic r,
                                   input logic f, input logic xr, input logic xv,
                                   input logic cd, input logic [DW-1:0] xd,
                                   input logic xl, input logic [15:0] xp);
        vec_t v;
        v.empty = e; v.rdData = d; v.ready = r; v.flushIn = f;
        v.expRdEn = xr; v.expValid = xv; v.checkData = cd; v.expData = xd;
        v.expLast = xl; v.expPkt = xp;
        return v;
    endfunction

    // Drive one table row at the falling edge and check the outputs it produces
    // before the next rising edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        fifo_empty   = v.empty;
        fifo_rd_data = v.rdData;
        m_ready      = v.ready;
        flush        = v.flushIn;
        #1;
        checkOutput($sformatf("vec%0d rd_en", idx), {31'd0, fifo_rd_en}, {31'd0, v.expRdEn});
        checkOutput($sformatf("vec%0d valid", idx), {31'd0, m_valid}, {31'd0, v.expValid});
        checkOutput($sformatf("vec%0d last", idx), {31'd0, m_last}, {31'd0, v.expLast});
        checkOutput($sformatf("vec%0d pkt", idx), {16'd0, pkt_count}, {16'd0, v.expPkt});
        if (v.checkData) begin
            checkOutput($sformatf("vec%0d data", idx), m_data, v.expData);
        end
    endtask

    // One cycle against a FIFO modelled by srcQ: the head is presented as FWFT
    // data, handshakes are logged, and the head is removed when the DUT pops.
    task automatic driveCycle(input bit ready, input bit flushIn, input bit holdEmpty);
        @(negedge clk);
        fifo_empty   = holdEmpty || (srcQ.size() == 0);
        fifo_rd_data = (srcQ.size() != 0) ? srcQ[0] : 32'hDEAD_BEEF;
        m_ready      = ready;
        flush        = flushIn;
        #1;
        lastRdEn = fifo_rd_en;
        if (m_valid && ready && !flushIn) begin
            outData.push_back(m_data);
            outLast.push_back(m_last);
            outCycle.push_back(cycleNo);
        end
        @(posedge clk);
        cycleNo++;
        if (lastRdEn) begin
            void'(srcQ.pop_front());
            popCount++;
        end
    endtask

    task automatic drainUntil(input int want, input int budget);
        int c;
        c = 0;
        while (outData.size() < want && c < budget) begin
            driveCycle(1'b1, 1'b0, 1'b0);
            c++;
        end
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst          = 1'b1;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        m_ready      = 1'b0;
        flush        = 1'b0;
        srcQ.delete();
        outData.delete();
        outLast.delete();
        outCycle.delete();
        popCount = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int startCycle;
        int errs;
        int lastErrs;
        rst          = 1'b1;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        m_ready      = 1'b0;
        flush        = 1'b0;
        lastRdEn     = 1'b0;

        // Reset values, with the FIFO non-empty so reset alone must block pops.
        @(negedge clk);
        fifo_empty   = 1'b0;
        fifo_rd_data = 32'hCAFE_F00D;
        #1;
        checkOutput("reset rd_en", {31'd0, fifo_rd_en}, 32'd0);
        checkOutput("reset valid", {31'd0, m_valid}, 32'd0);
        checkOutput("reset last", {31'd0, m_last}, 32'd0);
        checkOutput("reset data", m_data, 32'd0);
        checkOutput("reset pkt", {16'd0, pkt_count}, 32'd0);
        resetDut();

        // Cycle-by-cycle table: {empty, data, ready, flush} -> {rd_en, valid, data?, last, pkt}
        vecs[0]  = mkVec(1, 32'hDEAD_0000, 1, 0,  0, 0, 1, 32'h0000_0000, 0, 16'd0);
        vecs[1]  = mkVec(0, 32'h1122_3344, 1, 0,  1, 0, 1, 32'h0000_0000, 0, 16'd0);
        vecs[2]  = mkVec(1, 32'hDEAD_0001, 1, 0,  0, 1, 1, 32'h1122_3344, 0, 16'd0);
        vecs[3]  = mkVec(0, 32'hA000_0001, 0, 0,  1, 0, 0, 32'h0000_0000, 0, 16'd0);
        vecs[4]  = mkVec(0, 32'hA000_0002, 0, 0,  1, 1, 1, 32'hA000_0001, 0, 16'd0);
        vecs[5]  = mkVec(0, 32'hA000_0003, 0, 0,  0, 1, 1, 32'hA000_0001, 0, 16'd0);
        vecs[6]  = mkVec(0, 32'hA000_0003, 1, 0,  0, 1, 1, 32'hA000_0001, 0, 16'd0);
        vecs[7]  = mkVec(0, 32'hA000_0003, 1, 0,  1, 1, 1, 32'hA000_0002, 0, 16'd0);
        vecs[8]  = mkVec(1, 32'hDEAD_0002, 1, 0,  0, 1, 1, 32'hA000_0003, 1, 16'd0);
        vecs[9]  = mkVec(1, 32'hDEAD_0003, 1, 0,  0, 0, 0, 32'h0000_0000, 0, 16'd1);
        vecs[10] = mkVec(0, 32'hB000_0001, 1, 1,  0, 0, 0, 32'h0000_0000, 0, 16'd1);
        vecs[11] = mkVec(0, 32'hB000_0001, 0, 0,  1, 0, 0, 32'h0000_0000, 0, 16'd1);
        vecs[12] = mkVec(1, 32'hDEAD_0004, 1, 1,  0, 1, 1, 32'hB000_0001, 0, 16'd1);
        vecs[13] = mkVec(1, 32'hDEAD_0005, 1, 0,  0, 0, 0, 32'h0000_0000, 0, 16'd1);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Streaming: 8 words back to back, two full packets.
        $display("[TB] streaming");
        resetDut();
        for (int i = 0; i < 8; i++) srcQ.push_back(DW'(i));
        startCycle = cycleNo;
        drainUntil(8, 30);
        checkOutput("stream count", DW'(outData.size()), 32'd8);
        for (int i = 0; i < outData.size(); i++) begin
            checkOutput($sformatf("stream data%0d", i), outData[i], DW'(i));
            checkOutput($sformatf("stream last%0d", i), {31'd0, outLast[i]},
                        (i == 3 || i == 7) ? 32'd1 : 32'd0);
        end
        if (outData.size() == 8) begin
            checkOutput("stream latency", DW'(outCycle[0] - startCycle), 32'd1);
            checkOutput("stream back-to-back", DW'(outCycle[7] - outCycle[0]), 32'd7);
        end
        checkOutput("stream pkt", {16'd0, pkt_count}, 32'd2);

        // Backpressure: only two words may be taken while the sink stalls.
        $display("[TB] backpressure");
        resetDut();
        for (int i = 0; i < 10; i++) srcQ.push_back(32'h100 + DW'(i));
        for (int i = 0; i < 6; i++) driveCycle(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("bp pops", DW'(popCount), 32'd2);
        checkOutput("bp rd_en full", {31'd0, fifo_rd_en}, 32'd0);
        checkOutput("bp valid", {31'd0, m_valid}, 32'd1);
        checkOutput("bp held data", m_data, 32'h100);
        drainUntil(10, 60);
        checkOutput("bp count", DW'(outData.size()), 32'd10);
        errs = 0;
        for (int i = 0; i < outData.size(); i++) begin
            if (outData[i] !== 32'h100 + DW'(i)) errs++;
        end
        checkOutput("bp order errors", DW'(errs), 32'd0);

        // Flush with two beats buffered at beat index 2.
        $display("[TB] flush");
        resetDut();
        srcQ.push_back(32'h200);
        srcQ.push_back(32'h201);
        for (int i = 0; i < 4; i++) driveCycle(1'b1, 1'b0, 1'b0);
        checkOutput("flush pre beats", DW'(outData.size()), 32'd2);
        outData.delete();
        outLast.delete();
        for (int i = 0; i < 6; i++) srcQ.push_back(32'h300 + DW'(i));
        for (int i = 0; i < 4; i++) driveCycle(1'b0, 1'b0, 1'b0);
        checkOutput("flush pre pops", DW'(popCount), 32'd4);
        driveCycle(1'b1, 1'b1, 1'b0);
        checkOutput("flush rd_en", {31'd0, lastRdEn}, 32'd0);
        checkOutput("flush no pop", DW'(popCount), 32'd4);
        #1;
        checkOutput("flush valid after", {31'd0, m_valid}, 32'd0);
        drainUntil(4, 30);
        checkOutput("flush post count", DW'(outData.size()), 32'd4);
        for (int i = 0; i < outData.size(); i++) begin
            checkOutput($sformatf("flush data%0d", i), outData[i], 32'h302 + DW'(i));
            checkOutput($sformatf("flush last%0d", i), {31'd0, outLast[i]},
                        (i == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("flush pkt", {16'd0, pkt_count}, 32'd1);

        // Reset in the middle of a stalled stream with five packets done.
        $display("[TB] reset mid-stream");
        resetDut();
        for (int i = 0; i < 20; i++) srcQ.push_back(32'h400 + DW'(i));
        drainUntil(20, 60);
        checkOutput("mid pkt before", {16'd0, pkt_count}, 32'd5);
        for (int i = 0; i < 4; i++) srcQ.push_back(32'h450 + DW'(i));
        for (int i = 0; i < 3; i++) driveCycle(1'b0, 1'b0, 1'b0);
        checkOutput("mid full rd_en", {31'd0, lastRdEn}, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid rst valid", {31'd0, m_valid}, 32'd0);
        checkOutput("mid rst last", {31'd0, m_last}, 32'd0);
        checkOutput("mid rst data", m_data, 32'd0);
        checkOutput("mid rst rd_en", {31'd0, fifo_rd_en}, 32'd0);
        checkOutput("mid rst pkt", {16'd0, pkt_count}, 32'd0);
        resetDut();
        for (int i = 0; i < 4; i++) srcQ.push_back(32'h500 + DW'(i));
        drainUntil(4, 30);
        checkOutput("mid post count", DW'(outData.size()), 32'd4);
        for (int i = 0; i < outData.size(); i++) begin
            checkOutput($sformatf("mid post last%0d", i), {31'd0, outLast[i]},
                        (i == 3) ? 32'd1 : 32'd0);
        end
        if (outData.size() > 0) checkOutput("mid post first", outData[0], 32'h500);
        checkOutput("mid post pkt", {16'd0, pkt_count}, 32'd1);

        // Randomized ready and FIFO availability over 1000 words.
        $display("[TB] random");
        resetDut();
        for (int i = 0; i < 1000; i++) srcQ.push_back(32'hA5A5_0000 ^ DW'(i * 7));
        begin
            int c;
            c = 0;
            while (outData.size() < 1000 && c < 20000) begin
                driveCycle(1'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 3) == 0));
                c++;
            end
            #1;
        end
        checkOutput("rand count", DW'(outData.size()), 32'd1000);
        errs = 0;
        lastErrs = 0;
        for (int i = 0; i < outData.size(); i++) begin
            if (outData[i] !== (32'hA5A5_0000 ^ DW'(i * 7))) errs++;
            if (outLast[i] != ((i % 4) == 3)) lastErrs++;
        end
        checkOutput("rand order errors", DW'(errs), 32'd0);
        checkOutput("rand last errors", DW'(lastErrs), 32'd0);
        checkOutput("rand pkt", {16'd0, pkt_count}, 32'd250);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
